// File: rtl/change_dispenser.sv
// Coin payout sequencer: pulses nickel/dime solenoids, confirms each drop and tracks tube inventory.
// Optional CHANGE_SENSE_TIMEOUT_EN: fault when the drop sensor stays silent for TIMEOUT_CYCLES.
module change_dispenser #(
  parameter int unsigned PULSE_CYCLES   = 100000,
  parameter int unsigned GAP_CYCLES     = 200000,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  INIT_NICKELS   = 8'd20,
  parameter logic [7:0]  INIT_DIMES     = 8'd20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       r5,
  input  logic       r10,
  input  logic       r20,
  input  logic       coin_sensed,
  input  logic       refill,
  input  logic [7:0] refill_nickels,
  input  logic [7:0] refill_dimes,
  output logic       eject_nickel,
  output logic       eject_dime,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] remaining,
  output logic [7:0] nickel_count,
  output logic [7:0] dime_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SELECT    = 3'd1;
  localparam logic [2:0] S_PULSE     = 3'd2;
  localparam logic [2:0] S_WAIT_DROP = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_FAULT     = 3'd6;

  logic [2:0]  r_state;
  logic [31:0] r_cnt;
  logic        r_sel_dime;
  logic        r_sensed;
  logic        r_counted;
  logic [7:0]  r_prev_amt;
  logic [7:0]  r_remaining;
  logic [7:0]  r_nickels;
  logic [7:0]  r_dimes;

  logic [7:0]  w_amt;
  logic        w_accept;
  logic        w_take;
  logic [7:0]  w_coin_val;

  always_comb begin
    w_amt = '0;
    case ({r20, r10, r5})
      3'b001:  w_amt = 8'd5;
      3'b010:  w_amt = 8'd10;
      3'b011:  w_amt = 8'd15;
      3'b100:  w_amt = 8'd20;
      default: w_amt = '0;
    endcase
  end

  assign w_accept   = (r_state == S_IDLE) && (w_amt != '0) && (r_prev_amt == '0);
  assign w_coin_val = r_sel_dime ? 8'd10 : 8'd5;
  // A drop latched during PULSE is booked on the PULSE->WAIT_DROP edge; r_counted then skips the wait.
  assign w_take = ((r_state == S_PULSE) && (r_cnt == '0) && (r_sensed || coin_sensed)) ||
                  ((r_state == S_WAIT_DROP) && !r_counted && coin_sensed);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sel_dime  <= 1'b0;
      r_sensed    <= 1'b0;
      r_counted   <= 1'b0;
      r_prev_amt  <= '0;
      r_remaining <= '0;
      r_nickels   <= INIT_NICKELS;
      r_dimes     <= INIT_DIMES;
    end else begin
      r_prev_amt <= w_amt;
      case (r_state)
        S_IDLE: begin
          if (refill) begin
            r_nickels <= refill_nickels;
            r_dimes   <= refill_dimes;
          end
          if (w_accept) begin
            r_remaining <= w_amt;
            r_state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          r_sensed <= 1'b0;
          r_cnt    <= PULSE_CYCLES - 1;
          if (r_remaining == '0) begin
            r_state <= S_DONE;
          end else if ((r_remaining >= 8'd10) && (r_dimes != '0)) begin
            r_sel_dime <= 1'b1;
            r_state    <= S_PULSE;
          end else if (r_nickels != '0) begin
            r_sel_dime <= 1'b0;
            r_state    <= S_PULSE;
          end else begin
            r_state <= S_FAULT;
          end
        end
        S_PULSE: begin
          if (coin_sensed) r_sensed <= 1'b1;
          if (r_cnt == '0) begin
            r_cnt     <= TIMEOUT_CYCLES - 1;
            r_counted <= r_sensed || coin_sensed;
            r_sensed  <= 1'b0;
            r_state   <= S_WAIT_DROP;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_WAIT_DROP: begin
          if (r_counted || coin_sensed) begin
            r_counted <= 1'b0;
            r_cnt     <= GAP_CYCLES - 1;
            r_state   <= S_GAP;
          end else begin
`ifdef CHANGE_SENSE_TIMEOUT_EN
            if (r_cnt == '0) r_state <= S_FAULT;
            else             r_cnt   <= r_cnt - 32'd1;
`else
            r_state <= S_WAIT_DROP;
`endif
          end
        end
        S_GAP: begin
          if (r_cnt == '0) r_state <= S_SELECT;
          else             r_cnt   <= r_cnt - 32'd1;
        end
        S_DONE: r_state <= S_IDLE;
        S_FAULT: begin
          if (refill) begin
            r_nickels <= refill_nickels;
            r_dimes   <= refill_dimes;
            r_state   <= S_SELECT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_take) begin
        r_remaining <= r_remaining - w_coin_val;
        if (r_sel_dime) r_dimes   <= r_dimes - 8'd1;
        else            r_nickels <= r_nickels - 8'd1;
      end
    end
  end

  assign eject_nickel = (r_state == S_PULSE) && !r_sel_dime;
  assign eject_dime   = (r_state == S_PULSE) && r_sel_dime;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign fault        = (r_state == S_FAULT);
  assign remaining    = r_remaining;
  assign nickel_count = r_nickels;
  assign dime_count   = r_dimes;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected eject/done events queued at request time.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       r5 = 1'b0, r10 = 1'b0, r20 = 1'b0;
  logic       coin_sensed = 1'b0;
  logic       refill = 1'b0;
  logic [7:0] refill_nickels = '0, refill_dimes = '0;
  logic       eject_nickel, eject_dime, busy, done, fault;
  logic [7:0] remaining, nickel_count, dime_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] kind;   // 0 nickel eject, 1 dime eject, 2 done
    logic [7:0] rem;    // remaining seen when the event appears
  } ev_t;
  ev_t sb[$];

  logic [7:0] m_nick = 8'd20;
  logic [7:0] m_dime = 8'd20;

  change_dispenser #(
    .PULSE_CYCLES(4), .GAP_CYCLES(3), .TIMEOUT_CYCLES(20),
    .INIT_NICKELS(8'd20), .INIT_DIMES(8'd20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .r5(r5), .r10(r10), .r20(r20),
    .coin_sensed(coin_sensed), .refill(refill),
    .refill_nickels(refill_nickels), .refill_dimes(refill_dimes),
    .eject_nickel(eject_nickel), .eject_dime(eject_dime),
    .busy(busy), .done(done), .fault(fault), .remaining(remaining),
    .nickel_count(nickel_count), .dime_count(dime_count)
  );

  always #5 clk = ~clk;

  // Monitor: pops scoreboard on every eject rise and done pulse, checks pulse width.
  logic m_prev_n = 1'b0, m_prev_d = 1'b0;
  int   m_width = 0;
  always @(negedge clk) begin
    ev_t e;
    if (!reset_n) begin
      m_prev_n = 1'b0; m_prev_d = 1'b0; m_width = 0;
    end else begin
      if (eject_nickel && eject_dime) begin
        checks++; errors++;
        $display("FAIL eject_exclusive: nickel=%0b dime=%0b, required not both", eject_nickel, eject_dime);
      end
      if ((eject_nickel && !m_prev_n) || (eject_dime && !m_prev_d)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL eject_event: unexpected eject dime=%0b remaining=%0d", eject_dime, remaining);
        end else begin
          e = sb.pop_front();
          if ({1'b0, eject_dime} !== e.kind || remaining !== e.rem) begin
            errors++;
            $display("FAIL eject_event: got kind=%0d rem=%0d, required kind=%0d rem=%0d",
                     {1'b0, eject_dime}, remaining, e.kind, e.rem);
          end
        end
      end
      if (eject_nickel || eject_dime) m_width++;
      else if (m_prev_n || m_prev_d) begin
        checks++;
        if (m_width !== 4) begin
          errors++;
          $display("FAIL eject_width: got %0d cycles, required 4", m_width);
        end
        m_width = 0;
      end
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL done_event: unexpected done remaining=%0d", remaining);
        end else begin
          e = sb.pop_front();
          if (e.kind !== 2'd2 || remaining !== 8'd0) begin
            errors++;
            $display("FAIL done_event: got done rem=%0d, required kind=%0d rem=0", remaining, e.kind);
          end
        end
      end
      m_prev_n = eject_nickel;
      m_prev_d = eject_dime;
    end
  end

  task automatic push_payout(input logic [7:0] amt);
    logic [7:0] rem;
    rem = amt;
    while (rem != 8'd0) begin
      if (rem >= 8'd10 && m_dime != 8'd0) begin
        sb.push_back('{kind: 2'd1, rem: rem}); rem = rem - 8'd10; m_dime = m_dime - 8'd1;
      end else if (m_nick != 8'd0) begin
        sb.push_back('{kind: 2'd0, rem: rem}); rem = rem - 8'd5; m_nick = m_nick - 8'd1;
      end else begin
        return;
      end
    end
    sb.push_back('{kind: 2'd2, rem: 8'd0});
  endtask

  // Steps cycles, answering each eject fall with a sensor pulse when sense=1, until busy drops.
  task automatic run_payout(input int budget, input bit sense, output bit finished);
    bit seen, prev_ej, ej;
    finished = 1'b0;
    seen = busy;
    prev_ej = eject_nickel | eject_dime;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      ej = eject_nickel | eject_dime;
      coin_sensed = sense && prev_ej && !ej;
      prev_ej = ej;
      if (busy) seen = 1'b1;
      else if (seen) begin finished = 1'b1; break; end
    end
    coin_sensed = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    {r20, r10, r5} = 3'b000;
    coin_sensed = 1'b0; refill = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    m_nick = 8'd20; m_dime = 8'd20;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_refill(input logic [7:0] n, input logic [7:0] d);
    refill_nickels = n; refill_dimes = d; refill = 1'b1;
    m_nick = n; m_dime = d;
    @(negedge clk);
    refill = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({eject_nickel, eject_dime, busy, done, fault} !== 5'b0 || remaining !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl: ej=%b%b busy=%b done=%b fault=%b rem=%0d, required all 0",
               eject_nickel, eject_dime, busy, done, fault, remaining);
    end
    checks++;
    if (nickel_count !== 8'd20 || dime_count !== 8'd20) begin
      errors++;
      $display("FAIL reset_inventory: n=%0d d=%0d, required 20/20", nickel_count, dime_count);
    end
    do_reset();
  endtask

  task automatic test_r20();
    bit fin;
    {r20, r10, r5} = 3'b100;
    push_payout(8'd20);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || remaining !== 8'd20 || eject_dime !== 1'b0) begin
      errors++;
      $display("FAIL r20_accept: busy=%b rem=%0d ej=%b, required 1/20/0", busy, remaining, eject_dime);
    end
    @(negedge clk);
    checks++;
    if (eject_dime !== 1'b1) begin
      errors++;
      $display("FAIL r20_eject_latency: eject_dime=%b, required 1", eject_dime);
    end
    run_payout(200, 1'b1, fin);
    {r20, r10, r5} = 3'b000;
    checks++;
    if (!fin || remaining !== 8'd0 || dime_count !== m_dime || busy !== 1'b0) begin
      errors++;
      $display("FAIL r20_end: fin=%b rem=%0d dimes=%0d busy=%b, required 1/0/%0d/0",
               fin, remaining, dime_count, m_dime, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_r15();
    bit fin;
    {r20, r10, r5} = 3'b011;
    push_payout(8'd15);
    run_payout(200, 1'b1, fin);
    {r20, r10, r5} = 3'b000;
    checks++;
    if (!fin || remaining !== 8'd0 || dime_count !== m_dime || nickel_count !== m_nick) begin
      errors++;
      $display("FAIL r15_end: fin=%b rem=%0d n=%0d d=%0d, required 1/0/%0d/%0d",
               fin, remaining, nickel_count, dime_count, m_nick, m_dime);
    end
    @(negedge clk);
  endtask

  task automatic test_no_dimes();
    bit fin;
    do_reset();
    do_refill(8'd20, 8'd0);
    {r20, r10, r5} = 3'b100;
    push_payout(8'd20);
    run_payout(300, 1'b1, fin);
    {r20, r10, r5} = 3'b000;
    checks++;
    if (!fin || nickel_count !== 8'd16 || dime_count !== 8'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL no_dimes_end: fin=%b n=%0d d=%0d pending=%0d, required 1/16/0/0",
               fin, nickel_count, dime_count, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_empty_fault();
    bit fin, hit;
    do_reset();
    do_refill(8'd0, 8'd0);
    {r20, r10, r5} = 3'b001;
    push_payout(8'd5);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      hit = fault;
    end
    checks++;
    if (!hit || remaining !== 8'd5 || busy !== 1'b1 || eject_nickel !== 1'b0) begin
      errors++;
      $display("FAIL empty_fault: fault=%b rem=%0d busy=%b ej=%b, required 1/5/1/0",
               hit, remaining, busy, eject_nickel);
    end
    do_refill(8'd3, 8'd0);
    push_payout(8'd5);
    checks++;
    if (fault !== 1'b0 || nickel_count !== 8'd3) begin
      errors++;
      $display("FAIL refill_clear: fault=%b n=%0d, required 0/3", fault, nickel_count);
    end
    run_payout(100, 1'b1, fin);
    {r20, r10, r5} = 3'b000;
    checks++;
    if (!fin || nickel_count !== 8'd2 || remaining !== 8'd0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL refill_resume: fin=%b n=%0d rem=%0d fault=%b, required 1/2/0/0",
               fin, nickel_count, remaining, fault);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit seen_rise, seen_fall;
    int k;
    do_reset();
    {r20, r10, r5} = 3'b001;
    sb.push_back('{kind: 2'd0, rem: 8'd5});
    seen_rise = 1'b0; seen_fall = 1'b0;
    for (int i = 0; i < 20 && !seen_fall; i++) begin
      @(negedge clk);
      if (eject_nickel) seen_rise = 1'b1;
      else if (seen_rise) seen_fall = 1'b1;
    end
    checks++;
    if (!seen_fall) begin
      errors++;
      $display("FAIL timeout_pulse: eject fall seen=%b, required 1", seen_fall);
    end
`ifdef CHANGE_SENSE_TIMEOUT_EN
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (fault) begin k = i; break; end
    end
    checks++;
    if (k !== 20 || remaining !== 8'd5 || nickel_count !== 8'd20) begin
      errors++;
      $display("FAIL sense_timeout: fault after %0d rem=%0d n=%0d, required 20/5/20",
               k, remaining, nickel_count);
    end
`else
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (fault || !busy) k = i;
    end
    checks++;
    if (k !== 0 || busy !== 1'b1 || remaining !== 8'd5 || nickel_count !== 8'd20) begin
      errors++;
      $display("FAIL sense_wait: bad cycle %0d busy=%b rem=%0d n=%0d, required 0/1/5/20",
               k, busy, remaining, nickel_count);
    end
`endif
    do_reset();
  endtask

  task automatic test_rearm_and_reset();
    bit fin, hit;
    {r20, r10, r5} = 3'b001;
    push_payout(8'd5);
    run_payout(100, 1'b1, fin);
    repeat (6) @(negedge clk);
    checks++;
    if (!fin || busy !== 1'b0 || nickel_count !== 8'd19 || sb.size() != 0) begin
      errors++;
      $display("FAIL held_request: fin=%b busy=%b n=%0d pending=%0d, required 1/0/19/0",
               fin, busy, nickel_count, sb.size());
    end
    {r20, r10, r5} = 3'b000;
    @(negedge clk);
    {r20, r10, r5} = 3'b001;
    push_payout(8'd5);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      hit = eject_nickel;
    end
    checks++;
    if (!hit || remaining !== 8'd5) begin
      errors++;
      $display("FAIL rearm_payout: eject=%b rem=%0d, required 1/5", hit, remaining);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (eject_nickel !== 1'b0 || eject_dime !== 1'b0 || remaining !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ej=%b%b rem=%0d busy=%b, required 00/0/0",
               eject_nickel, eject_dime, remaining, busy);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_r20();
    test_r15();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d events pending, required 0", sb.size());
    end
    test_no_dimes();
    test_empty_fault();
    test_timeout();
    test_rearm_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
